// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 master serializer, MSB first.
// One W_DATA-bit word per valid/ready handshake; the received word is returned
// with a single-cycle rx_valid pulse when the engine drops back to IDLE.
// Optional build macro SPI_SHIFT_LOOPBACK_EN: sample spi_mosi instead of spi_miso.
module spi_shift_engine #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_DATA-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (W_DATA > 1) ? $clog2(W_DATA) : 1;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_shift_engine: CLK_DIV must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     hcnt_q, hcnt_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [W_DATA-1:0] tx_shift, tx_shift_d;
    logic [W_DATA-1:0] rx_shift, rx_shift_d;
    logic [W_DATA-1:0] rx_data_d;
    logic              sclk_d, cs_n_d, mosi_d, tx_ready_d, rx_valid_d;
    logic              half_done;
    logic              miso_s;

`ifdef SPI_SHIFT_LOOPBACK_EN
    // Self-test: the transmitted bit stream is looped straight back.
    assign miso_s = spi_mosi;
`else
    assign miso_s = spi_miso;
`endif

    assign half_done = (hcnt_q == CW'(CLK_DIV - 1));

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        bcnt_d     = bcnt_q;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        sclk_d     = spi_sclk;
        cs_n_d     = spi_cs_n;
        mosi_d     = spi_mosi;
        tx_ready_d = tx_ready;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_d    = LEAD;
                    hcnt_d     = '0;
                    bcnt_d     = '0;
                    tx_shift_d = tx_data;
                    cs_n_d     = 1'b0;
                    mosi_d     = tx_data[W_DATA-1];
                    tx_ready_d = 1'b0;
                end
            end
            LEAD: begin
                // CS asserted with first MSB on the wire, SCLK still low.
                if (half_done) begin
                    state_d = SHIFT;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!half_done) begin
                    hcnt_d = hcnt_q + 1'b1;
                end else if (!spi_sclk) begin
                    // Rising edge: capture MISO, MSB-first assembly.
                    hcnt_d     = '0;
                    sclk_d     = 1'b1;
                    rx_shift_d = (rx_shift << 1) | W_DATA'(miso_s);
                end else if (bcnt_q == BW'(W_DATA - 1)) begin
                    // Final fall after the last bit: no MOSI shift, go to TRAIL.
                    state_d = TRAIL;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    sclk_d  = 1'b0;
                end else begin
                    // Falling edge: present the next bit.
                    hcnt_d     = '0;
                    bcnt_d     = bcnt_q + 1'b1;
                    sclk_d     = 1'b0;
                    tx_shift_d = tx_shift << 1;
                    mosi_d     = tx_shift_d[W_DATA-1];
                end
            end
            TRAIL: begin
                // CS hold after the last fall, then deliver the word.
                if (half_done) begin
                    state_d    = IDLE;
                    hcnt_d     = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_shift;
                    rx_valid_d = 1'b1;
                    tx_ready_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, shifters and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            tx_ready <= 1'b1;
            rx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            spi_sclk <= sclk_d;
            spi_cs_n <= cs_n_d;
            spi_mosi <= mosi_d;
            tx_ready <= tx_ready_d;
            rx_valid <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: scoreboard bench for spi_shift_engine.
// Handshakes push the expected word into a queue; a monitor plays the SPI
// slave, collects MOSI bits and checks each rx_valid pulse against the queue.
module tb_spi_shift_engine;

    localparam int W       = 32;
    localparam int CLK_DIV = 4;
    localparam int LAT     = 1 + CLK_DIV + 2 * W * CLK_DIV + CLK_DIV;

    logic         clk, rst;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         spi_sclk, spi_cs_n, spi_mosi, spi_miso;

    spi_shift_engine #(.W_DATA(W), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           errs = 0;
    int           checks = 0;
    logic [W-1:0] drv_miso;   // word the slave will return for the next handshake

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor + slave model, sampled on the falling clk edge.
    initial begin
        exp_t         e;
        logic [W-1:0] mosi_word = '0;
        logic [W-1:0] cur_miso = '0;
        logic         prev_sclk = 1'b0;
        int           rises = 0, low_run = 0, k = 0, cyc = 0;
        spi_miso = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                mosi_word = '0; prev_sclk = 1'b0;
                rises = 0; low_run = 0; k = 0;
            end else begin
                if (spi_sclk && !prev_sclk) begin
                    mosi_word = (mosi_word << 1) | W'(spi_mosi);
                    rises++;
                end
                if (!spi_sclk && prev_sclk) k++;
                if (spi_cs_n) k = 0;
                prev_sclk = spi_sclk;
                if (!tx_ready) low_run++;
                if (rx_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rx_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rx_data", rx_data, e.rx);
                        chk("mosi_word", mosi_word, e.tx);
                        chk("sclk_rises", W'(rises), W'(W));
                        chk("latency", W'(cyc - e.cyc), W'(LAT));
                        chk("tx_ready_low", W'(low_run), W'(LAT - 1));
                        chk("idle_pins", {spi_cs_n, spi_sclk, spi_mosi}, 3'b100);
                    end
                    rises = 0; low_run = 0; mosi_word = '0;
                end
                if (tx_valid && tx_ready) begin
                    e.tx  = tx_data;
`ifdef SPI_SHIFT_LOOPBACK_EN
                    e.rx  = tx_data;
`else
                    e.rx  = drv_miso;
`endif
                    e.cyc = cyc;
                    q.push_back(e);
                    cur_miso = drv_miso;
                end
            end
            spi_miso = (k < W) ? cur_miso[W-1-k] : 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] m);
        int t = 0;
        @(posedge clk); #1;
        tx_data = d; drv_miso = m; tx_valid = 1'b1;
        while (!tx_ready && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 1000) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk); t++;
        end
        if (t >= 2000) chk("done_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t, pulses;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; drv_miso = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_mosi", spi_mosi, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        send(32'h8000_0001, $urandom); wait_done();
        send($urandom, 32'hFFFF_FFFF); wait_done();
        send(32'hA5A5_0F0F, $urandom); wait_done();

        // Held tx_valid: second word must be taken on the rx_valid cycle.
        @(posedge clk); #1;
        tx_data = 32'h1234_5678; drv_miso = $urandom; tx_valid = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        tx_data = 32'hDEAD_BEEF; drv_miso = $urandom;
        t = 0;
        while (!rx_valid && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 1000) chk("b2b_timeout", 1, 0);
        chk("b2b_gap_cs_high", spi_cs_n, 1);
        chk("b2b_ready_on_rx_valid", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("b2b_gap_cs_low_after", spi_cs_n, 0);
        wait_done();

        // Async reset 100 cycles into a transfer.
        send($urandom, $urandom);
        repeat (98) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", spi_cs_n, 1);
        chk("mid_rst_sclk", spi_sclk, 0);
        chk("mid_rst_tx_ready", tx_ready, 1);
        chk("mid_rst_rx_valid", rx_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (rx_valid) pulses++;
        end
        chk("mid_rst_no_pulse", W'(pulses), 0);
        chk("mid_rst_rx_data", rx_data, 0);
        send(32'h0000_FFFF, $urandom); wait_done();

        // Random traffic with random gaps.
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom);
            if ($urandom_range(0, 1) == 1) wait_done();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        wait_done();
        chk("queue_empty", W'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master serializer, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the CPU-side SPI register file.
- Takes one W_DATA-bit word per valid/ready handshake, drives SCLK/CS_N/MOSI, and samples MISO.
- Returns the received word with a one-cycle valid pulse; the register file consumes it into its MISO register.

Parameters:
- W_DATA, 32, word width in bits; one transaction is W_DATA SCLK periods.
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range >= 1; elaboration error if < 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  W_DATA  word to transmit; sampled only on handshake.
- tx_valid  in  1  upstream has a word.
- tx_ready  out  1  engine idle and able to accept a word.
- rx_data  out  W_DATA  last fully received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- spi_sclk  out  1  serial clock.
- spi_cs_n  out  1  chip select, active-low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, spi_sclk=0, spi_cs_n=1, spi_mosi=0; FSM=IDLE; all counters 0.
- Reset mid-transfer: all of the above take effect immediately. The partial word is discarded and no rx_valid pulse is produced.
- All outputs are registered.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - tx_ready=1, cs_n=1, sclk=0.
  - When tx_valid && tx_ready in a cycle, tx_data is latched into tx_shift and the FSM goes to LEAD next cycle.
  - tx_ready=0 from the next cycle until the FSM re-enters IDLE.
  - tx_valid while busy is ignored; there is no queuing.
- LEAD:
  - cs_n=0, mosi=tx_shift[W_DATA-1], sclk=0, held for CLK_DIV cycles, then SHIFT.
- SHIFT:
  - Half-period counter toggles sclk every CLK_DIV cycles.
  - Rising edge: shift spi_miso into rx_shift LSB (MSB-first assembly).
  - Falling edge: shift tx_shift left by 1 and drive the new MSB on mosi.
  - Bit counter counts rising edges, 0..W_DATA-1.
  - After the W_DATA-th rising edge, sclk returns low CLK_DIV cycles later; no mosi shift on that final fall. Then go to TRAIL.
  - SHIFT lasts exactly 2*W_DATA*CLK_DIV cycles.
- TRAIL:
  - sclk=0, cs_n=0 for CLK_DIV cycles, then go to IDLE.
  - On the IDLE-entry cycle: cs_n=1, rx_data<=rx_shift, rx_valid=1 for exactly that one cycle, tx_ready=1.
- Latency: from handshake cycle to rx_valid is 1 + CLK_DIV + 2*W_DATA*CLK_DIV + CLK_DIV cycles. With defaults this is 265.
- Back-to-back: if tx_valid is held high, the next handshake occurs on the same cycle rx_valid pulses. cs_n is therefore high for a minimum of 1 cycle between words.
- rx_data holds its value between transfers. mosi returns to 0 in IDLE.
- All counters sized by $clog2 and wrap-free: they reset to 0 at every state change.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- Defined: the internal MISO sample source is spi_mosi; the spi_miso pin is ignored. Used for CPU-side self-test.
- Undefined: samples are taken from spi_miso. No loopback logic is present.
- Pin timing and behaviour are identical in both cases.

Test Plan:
- Reset release, then tx_data=0x80000001 with tx_valid for 1 cycle:
  - mosi bit sequence 1, thirty 0s, 1 across the 32 rising edges.
  - Exactly 32 sclk rising edges while cs_n=0.
  - tx_ready low for 264 cycles.
- spi_miso tied 1, any tx_data → rx_valid pulses once, 265 cycles after the handshake, with rx_data=0xFFFFFFFF.
- SPI_SHIFT_LOOPBACK_EN defined, tx_data=0xA5A50F0F → rx_data=0xA5A50F0F; rx_valid high exactly 1 cycle.
- tx_valid held high with tx_data=0x12345678, then changed to 0xDEADBEEF mid-transfer:
  - The first word transmits unaltered.
  - The second handshake occurs on the rx_valid cycle.
  - cs_n is high for exactly 1 cycle between words.
- rst asserted at cycle 100 of a transfer:
  - Same cycle: cs_n=1, sclk=0, tx_ready=1.
  - rx_data keeps 0 and no rx_valid pulse.
  - A new transfer of 0x0000FFFF afterwards completes correctly.
- CLK_DIV=1 build → sclk period is 2 clk cycles; the transfer completes 1+1+64+1 = 67 cycles after the handshake.
